traffic_light_controller: RTL and testbench

Moore FSM that sequences a two-road intersection: North-South is the main road and East-West is the side road. It owns a 6-bit phase timer that counts cycles spent in the current phase. It uses vehicle sensors and a latched pedestrian request to end main-road green early or hold side-road green. It drives the lamp outputs and the WALK indicator for the top-level traffic-light design.

---
 rtl/tl_pkg.sv | 35 +++
 rtl/phase_timer.sv | 42 ++++
 rtl/traffic_light_controller.sv | 148 ++++++++++++++
 tb/tb_traffic_light_controller.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tl_pkg
// Description : Shared types and constants for the traffic light controller:
//               controller state encoding, lamp encodings and timer helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package tl_pkg;

    // Controller phases; 6 legal codes in a 3-bit register, codes 6 and 7
    // are unreachable and recover to NS_GREEN.
    typedef enum logic [2:0] {
        ST_NS_GREEN  = 3'd0,
        ST_NS_YELLOW = 3'd1,
        ST_ALLRED_A  = 3'd2,
        ST_EW_GREEN  = 3'd3,
        ST_EW_YELLOW = 3'd4,
        ST_ALLRED_B  = 3'd5
    } tl_state_e;

    // One-hot lamp encoding {red, yellow, green}
    localparam logic [2:0] LAMP_RED = 3'b100;
    localparam logic [2:0] LAMP_YEL = 3'b010;
    localparam logic [2:0] LAMP_GRN = 3'b001;

    localparam int         TIMER_W   = 6;
    localparam logic [5:0] TIMER_MAX = 6'd63;

    // Timer value seen on the last cycle of a phase lasting 'cycles' cycles
    function automatic logic [TIMER_W-1:0] last_tick(input int cycles);
        return TIMER_W'(cycles - 1);
    endfunction

endpackage : tl_pkg
`default_nettype wire

// File: rtl/phase_timer.sv
`default_nettype none
// ============================================================================
// Module      : phase_timer
// Description : 6-bit phase cycle counter. Synchronous clear has priority
//               over counting; the count saturates at its maximum value.
// Revision    : 1.0 - initial release
// ============================================================================
module phase_timer
    import tl_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               clear_i,
    output logic [TIMER_W-1:0] count_o
);

    logic [TIMER_W-1:0] count_q;
    logic [TIMER_W-1:0] count_d;

    // Next count: clear to zero, otherwise increment until saturated
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (count_q != TIMER_MAX) begin
            count_d = count_q + 1'b1;
        end
    end

    // Count register with asynchronous reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule : phase_timer
`default_nettype wire

// File: rtl/traffic_light_controller.sv
`default_nettype none
// ============================================================================
// Module      : traffic_light_controller
// Description : Moore FSM sequencing a two-road intersection (NS main road,
//               EW side road) with vehicle sensing, latched pedestrian
//               request, minimum/maximum green and fixed yellow/all-red.
// Revision    : 1.0 - initial release
// ============================================================================
module traffic_light_controller
    import tl_pkg::*;
#(
    parameter int GREEN_MIN = 10,
    parameter int GREEN_MAX = 40,
    parameter int YELLOW_T  = 4,
    parameter int ALLRED_T  = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ns_car_i,
    input  logic               ew_car_i,
    input  logic               ped_req_i,
    output logic [2:0]         ns_light_o,
    output logic [2:0]         ew_light_o,
    output logic               walk_o,
    output logic [TIMER_W-1:0] phase_timer_o
);

    localparam logic [TIMER_W-1:0] c_GMIN_LAST = last_tick(GREEN_MIN);
    localparam logic [TIMER_W-1:0] c_GMAX_LAST = last_tick(GREEN_MAX);
    localparam logic [TIMER_W-1:0] c_YEL_LAST  = last_tick(YELLOW_T);
    localparam logic [TIMER_W-1:0] c_ARED_LAST = last_tick(ALLRED_T);

    tl_state_e          state_q;
    tl_state_e          state_d;
    logic               advance;
    logic               ped_pending_q;
    logic               ped_pending_d;
    logic [TIMER_W-1:0] timer;

    // Timer is cleared on every transition so each phase starts at zero
    phase_timer u_phase_timer (
        .clk     (clk),
        .reset   (reset),
        .clear_i (advance),
        .count_o (timer)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_NS_GREEN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; transitions are decided on the last cycle of a phase
    always_comb begin
        state_d = state_q;
        advance = 1'b0;
        case (state_q)
            ST_NS_GREEN: begin
                // ns_car has no effect here: NS already has green
                if (((timer >= c_GMIN_LAST) && (ew_car_i || ped_pending_q)) ||
                    (timer == c_GMAX_LAST)) begin
                    state_d = ST_NS_YELLOW;
                    advance = 1'b1;
                end
            end
            ST_NS_YELLOW: begin
                if (timer == c_YEL_LAST) begin
                    state_d = ST_ALLRED_A;
                    advance = 1'b1;
                end
            end
            ST_ALLRED_A: begin
                if (timer == c_ARED_LAST) begin
                    state_d = ST_EW_GREEN;
                    advance = 1'b1;
                end
            end
            ST_EW_GREEN: begin
                // Waiting NS traffic ends the side-road green at minimum
                if (((timer >= c_GMIN_LAST) && (!ew_car_i || ns_car_i)) ||
                    (timer == c_GMAX_LAST)) begin
                    state_d = ST_EW_YELLOW;
                    advance = 1'b1;
                end
            end
            ST_EW_YELLOW: begin
                if (timer == c_YEL_LAST) begin
                    state_d = ST_ALLRED_B;
                    advance = 1'b1;
                end
            end
            ST_ALLRED_B: begin
                if (timer == c_ARED_LAST) begin
                    state_d = ST_NS_GREEN;
                    advance = 1'b1;
                end
            end
            default: begin
                // Unreachable code: restart the cycle with a fresh timer
                state_d = ST_NS_GREEN;
                advance = 1'b1;
            end
        endcase
    end

    // Pedestrian latch: served on entry to EW_GREEN, a new press always wins
    always_comb begin
        ped_pending_d = ped_req_i |
                        (ped_pending_q & ~((state_q == ST_ALLRED_A) & advance));
    end

    // Pedestrian pending register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ped_pending_q <= 1'b0;
        end else begin
            ped_pending_q <= ped_pending_d;
        end
    end

    // Moore outputs decoded from the registered state only
    always_comb begin
        ns_light_o = LAMP_RED;
        ew_light_o = LAMP_RED;
        walk_o     = 1'b0;
        case (state_q)
            ST_NS_GREEN:  ns_light_o = LAMP_GRN;
            ST_NS_YELLOW: ns_light_o = LAMP_YEL;
            ST_EW_GREEN: begin
                ew_light_o = LAMP_GRN;
                walk_o     = 1'b1;
            end
            ST_EW_YELLOW: ew_light_o = LAMP_YEL;
            default: begin
                ns_light_o = LAMP_RED;
                ew_light_o = LAMP_RED;
            end
        endcase
    end

    assign phase_timer_o = timer;

endmodule : traffic_light_controller
`default_nettype wire

// File: tb/tb_traffic_light_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_traffic_light_controller
// Description : Self-checking bench: directed vector table, hand-written
//               corner sequences and randomized traffic against a
//               phase-table reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_traffic_light_controller;

    localparam int GREEN_MIN = 10;
    localparam int GREEN_MAX = 40;
    localparam int YELLOW_T  = 4;
    localparam int ALLRED_T  = 2;

    localparam logic [2:0] R = 3'b100;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] G = 3'b001;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ns_car = 1'b0;
    logic       ew_car = 1'b0;
    logic       ped_req = 1'b0;
    logic [2:0] ns_light;
    logic [2:0] ew_light;
    logic       walk;
    logic [5:0] phase_timer;

    int vectors = 0;
    int miscompares = 0;

    traffic_light_controller #(
        .GREEN_MIN (GREEN_MIN),
        .GREEN_MAX (GREEN_MAX),
        .YELLOW_T  (YELLOW_T),
        .ALLRED_T  (ALLRED_T)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .ns_car_i      (ns_car),
        .ew_car_i      (ew_car),
        .ped_req_i     (ped_req),
        .ns_light_o    (ns_light),
        .ew_light_o    (ew_light),
        .walk_o        (walk),
        .phase_timer_o (phase_timer)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1, "timeout");
    end

    // ---------------- reference model: phase index + elapsed cycles -------
    // phase 0..5 = NS green, NS yellow, all-red A, EW green, EW yellow, all-red B
    logic [2:0] lamp_ns [6];
    logic [2:0] lamp_ew [6];
    int m_phase;
    int m_t;
    bit m_ped;

    task automatic model_reset();
        m_phase = 0;
        m_t     = 0;
        m_ped   = 1'b0;
    endtask

    task automatic model_step(input bit ns, input bit ew, input bit ped);
        int  n;
        bit  leave;
        n = m_t + 1;   // cycles spent in this phase including the current one
        case (m_phase)
            0:       leave = ((n >= GREEN_MIN) && (ew || m_ped)) || (n == GREEN_MAX);
            1, 4:    leave = (n == YELLOW_T);
            2, 5:    leave = (n == ALLRED_T);
            default: leave = ((n >= GREEN_MIN) && (!ew || ns)) || (n == GREEN_MAX);
        endcase
        m_ped = ped || (m_ped && !(m_phase == 2 && leave));
        if (leave) begin
            m_phase = (m_phase + 1) % 6;
            m_t     = 0;
        end else begin
            m_t = (m_t < 63) ? m_t + 1 : 63;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_model(input string name);
        logic [12:0] exp;
        exp = {lamp_ns[m_phase], lamp_ew[m_phase], (m_phase == 3), 6'(m_t)};
        chk(name, {19'd0, ns_light, ew_light, walk, phase_timer}, {19'd0, exp});
    endtask

    // Called just after a falling edge; returns just after the next one
    task automatic tick(input bit ns, input bit ew, input bit ped, input string name = "model");
        ns_car  = ns;
        ew_car  = ew;
        ped_req = ped;
        @(posedge clk);
        model_step(ns, ew, ped);
        @(negedge clk);
        chk_model(name);
    endtask

    // Asynchronous assert: reset values must appear without any clock edge
    task automatic do_reset();
        reset   = 1'b1;
        ns_car  = 1'b0;
        ew_car  = 1'b0;
        ped_req = 1'b0;
        #1;
        model_reset();
        chk("reset_ns", {29'd0, ns_light}, {29'd0, G});
        chk("reset_ew", {29'd0, ew_light}, {29'd0, R});
        chk("reset_walk_timer", {25'd0, walk, phase_timer}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        chk_model("reset_release");
    endtask

    task automatic run_to(input int p, input int t, input bit ns, input bit ew);
        for (int k = 0; k < 200; k++) begin
            if (m_phase == p && m_t == t) return;
            tick(ns, ew, 1'b0);
        end
        chk("run_to_timeout", 32'(m_phase), 32'(p));
    endtask

    // Length of the NS green currently showing, ped optionally pulsed at cycle pk
    task automatic measure_green(input int pk, output int g);
        g = 0;
        for (int k = 0; k < 100; k++) begin
            if (ns_light != G) break;
            g++;
            tick(1'b0, 1'b0, (k == pk));
        end
    endtask

    typedef struct {
        bit         rst;
        bit         ns;
        bit         ew;
        bit         ped;
        int         hold;
        logic [2:0] e_ns;
        logic [2:0] e_ew;
        logic       e_walk;
        logic [5:0] e_t;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input bit rst, input bit ns, input bit ew, input bit ped, input int hold,
                       input logic [2:0] ens, input logic [2:0] eew, input logic ewk,
                       input logic [5:0] et);
        vec_t v;
        v.rst = rst; v.ns = ns; v.ew = ew; v.ped = ped; v.hold = hold;
        v.e_ns = ens; v.e_ew = eew; v.e_walk = ewk; v.e_t = et;
        tbl.push_back(v);
    endtask

    initial begin
        int g;
        int w;
        int last_t;
        lamp_ns = '{G, Y, R, R, R, R};
        lamp_ew = '{R, R, R, G, Y, R};
        model_reset();

        // Idle intersection: full 62-cycle round
        add(1, 0, 0, 0,  0, G, R, 0, 0);
        add(0, 0, 0, 0, 39, G, R, 0, 39);
        add(0, 0, 0, 0,  1, Y, R, 0, 0);
        add(0, 0, 0, 0,  3, Y, R, 0, 3);
        add(0, 0, 0, 0,  1, R, R, 0, 0);
        add(0, 0, 0, 0,  1, R, R, 0, 1);
        add(0, 0, 0, 0,  1, R, G, 1, 0);
        add(0, 0, 0, 0,  9, R, G, 1, 9);
        add(0, 0, 0, 0,  1, R, Y, 0, 0);
        add(0, 0, 0, 0,  3, R, Y, 0, 3);
        add(0, 0, 0, 0,  1, R, R, 0, 0);
        add(0, 0, 0, 0,  1, R, R, 0, 1);
        add(0, 0, 0, 0,  1, G, R, 0, 0);
        // Side-road car: NS green cut to minimum, EW green forced out at maximum
        add(1, 0, 1, 0,  0, G, R, 0, 0);
        add(0, 0, 1, 0,  9, G, R, 0, 9);
        add(0, 0, 1, 0,  1, Y, R, 0, 0);
        add(0, 0, 1, 0,  4, R, R, 0, 0);
        add(0, 0, 1, 0,  2, R, G, 1, 0);
        add(0, 0, 1, 0, 39, R, G, 1, 39);
        add(0, 0, 1, 0,  1, R, Y, 0, 0);

        foreach (tbl[i]) begin
            if (tbl[i].rst) do_reset();
            repeat (tbl[i].hold) tick(tbl[i].ns, tbl[i].ew, tbl[i].ped);
            chk($sformatf("table[%0d]", i),
                {19'd0, ns_light, ew_light, walk, phase_timer},
                {19'd0, tbl[i].e_ns, tbl[i].e_ew, tbl[i].e_walk, tbl[i].e_t});
        end

        // Single ped pulse at cycle 3: short NS green, one walk, then cleared
        do_reset();
        measure_green(3, g);
        chk("ped_ns_green_len", 32'(g), 32'd10);
        w = 0;
        for (int k = 0; k < 100; k++) begin
            if (ns_light == G) break;
            if (walk) w++;
            tick(1'b0, 1'b0, 1'b0);
        end
        chk("ped_walk_len", 32'(w), 32'd10);
        measure_green(-1, g);
        chk("ped_cleared_green_len", 32'(g), 32'd40);

        // Ped press on the ALLRED_A -> EW_GREEN cycle survives the clear
        do_reset();
        run_to(2, 1, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 100; k++) begin
            if (ns_light == G) break;
            tick(1'b0, 1'b0, 1'b0);
        end
        measure_green(-1, g);
        chk("ped_same_cycle_green_len", 32'(g), 32'd10);

        // Reset during EW_YELLOW with timer=2
        do_reset();
        run_to(4, 2, 1'b0, 1'b1);
        chk("pre_reset_ew", {29'd0, ew_light}, {29'd0, Y});
        chk("pre_reset_timer", {26'd0, phase_timer}, 32'd2);
        do_reset();

        // ew_car drops at EW_GREEN timer 5: minimum green still honoured
        do_reset();
        run_to(3, 5, 1'b0, 1'b1);
        last_t = -1;
        for (int k = 0; k < 50; k++) begin
            if (ew_light != G) break;
            last_t = int'(phase_timer);
            tick(1'b0, 1'b0, 1'b0);
        end
        chk("ew_min_green_last_timer", 32'(last_t), 32'd9);
        chk("ew_min_green_exit", {29'd0, ew_light}, {29'd0, Y});

        // Randomized traffic with occasional mid-phase resets
        do_reset();
        for (int k = 0; k < 4000; k++) begin
            if ($urandom_range(0, 599) == 0) begin
                do_reset();
            end else begin
                tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
                     1'($urandom_range(0, 19) == 0), "random");
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_traffic_light_controller
`default_nettype wire
